memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM register and consumes its M-suffixed outputs.
- Contains the word-addressed data memory, which writes on the clock edge and reads combinationally.
- Contains the MEM/WB pipeline register.
- Produces the W-suffixed signals and the writeback result mux output ResultW, which feed the register file and the hazard unit.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit data-memory words (default 256 words = 1 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of data-memory word 0; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteM  in  1  register-write control from EX/MEM.
- MemtoRegM  in  1  selects memory data as the writeback result.
- MemWriteM  in  1  store enable.
- ALUOutM  in  32  byte address for load/store, or the ALU result.
- WriteDataM  in  32  store data.
- WriteRegM  in  5  destination register number.
- RegWriteW  out  1  registered RegWriteM.
- MemtoRegW  out  1  registered MemtoRegM.
- ReadDataW  out  32  registered load data.
- ALUOutW  out  32  registered ALUOutM.
- WriteRegW  out  5  registered WriteRegM.
- ResultW  out  32  combinational: MemtoRegW ? ReadDataW : ALUOutW.
- MemErr  out  1  sticky flag: an access was misaligned or out of range.

Behaviour:
- Reset: on a rising clk edge with rst=1, all W registers and MemErr become 0, so ResultW=0. Data-memory contents are not affected by rst. The array is zero-initialised at time 0 only.
- Address decode:
  - offset = ALUOutM - BASE_ADDR.
  - index = offset[DEPTH_LOG2+1:2].
  - in_range = (offset[31:DEPTH_LOG2+2] == 0).
  - aligned = (offset[1:0] == 0).
  - valid = in_range && aligned.
- Read:
  - ReadDataM = valid ? mem[index] : 32'h0. It is combinational from ALUOutM in the same cycle.
  - The read is always evaluated. It is only meaningful when MemtoRegM=1.
- Write:
  - When MemWriteM=1 and valid=1, mem[index] <= WriteDataM at the rising edge.
  - When MemWriteM=1 and valid=0, no write occurs.
- Read-during-write to the same index in one cycle: ReadDataM returns the old contents. The new data is visible from the next cycle.
- Error detection: an access is (MemWriteM || MemtoRegM). If an access occurs with valid=0, MemErr <= 1 at the edge. MemErr stays 1 until rst. Non-access cycles never set MemErr, regardless of the ALUOutM value.
- Load latency: 1 cycle. The load issued in MEM at cycle N appears on ReadDataW and ResultW after edge N+1.
- MEM/WB register: every non-reset edge captures RegWriteM, MemtoRegM, ReadDataM, ALUOutM and WriteRegM. There is no stall or flush input. Bubbles arrive as RegWriteM=0 and MemWriteM=0 from upstream.
- A faulting load still writes back, with ReadDataW=0. The stage does not suppress RegWriteW.
- Reset mid-operation: a store presented in the same cycle as rst=1 is still performed, because the memory write is not gated by rst. The W registers clear regardless.
- Width rules: all arithmetic is 32-bit unsigned, and BASE_ADDR subtraction wraps modulo 2^32. Addresses below BASE_ADDR wrap to large offsets and therefore decode as out of range.

Decomposition:
- Shared package mips_pkg: WORD_W=32, REG_ADDR_W=5, and the default DEPTH_LOG2 constant.
- One sub-module, data_memory (parameters DEPTH_LOG2, BASE_ADDR). It holds the array plus the decode/valid logic and exposes ReadDataM and valid.
- The MEM/WB register, MemErr and the ResultW mux live in memory_stage itself.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> RegWriteW=0, MemtoRegW=0, ReadDataW=0, ALUOutW=0, WriteRegW=0, ResultW=0, MemErr=0.
- Store then load: store WriteDataM=32'hDEAD_BEEF to ALUOutM=32'h10; next cycle load (MemtoRegM=1, RegWriteM=1, WriteRegM=5'd8) from 32'h10 -> one cycle later ReadDataW=ResultW=32'hDEAD_BEEF, WriteRegW=8, MemErr=0.
- Read-during-write: mem[4]=32'h1111_1111; in one cycle store 32'h2222_2222 to 32'h10 with MemtoRegM=1 -> ReadDataW=32'h1111_1111; a load the following cycle -> 32'h2222_2222.
- ALU pass-through: MemtoRegM=0, RegWriteM=1, ALUOutM=32'h0000_0ABC, WriteRegM=3 -> next cycle ResultW=32'h0000_0ABC, RegWriteW=1, WriteRegW=3.
- Misaligned store to 32'h12 with data 32'h5 -> mem[4] unchanged, MemErr=1 and held across 10 idle cycles. A non-access cycle with ALUOutM=32'hFFFF_FFFF does not set MemErr in a fresh run.
- Out-of-range load at 32'h400 (DEPTH_LOG2=8) -> ReadDataW=0, MemErr=1; a subsequent rst=1 cycle clears MemErr to 0 while mem contents persist.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and defaults for the MIPS pipeline slice.
// Imported by the data memory and the MEM stage.
package mips_pkg;
  localparam int WORD_W         = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int DEPTH_LOG2_DEF = 8;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: write on the rising edge, combinational read.
// Decodes the byte address against BASE_ADDR and reports whether it is usable.
module data_memory
  import mips_pkg::*;
#(
  parameter int                DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [WORD_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              MemWriteM,
  input  logic [WORD_W-1:0] ALUOutM,
  input  logic [WORD_W-1:0] WriteDataM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              valid
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Zero at time 0 only; reset deliberately leaves the contents alone.
  logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

  logic [WORD_W-1:0]     offset;
  logic [DEPTH_LOG2-1:0] index;
  logic                  in_range;
  logic                  aligned;

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign offset   = ALUOutM - BASE_ADDR;
  assign index    = offset[DEPTH_LOG2+1:2];
  assign in_range = (offset[WORD_W-1:DEPTH_LOG2+2] == '0);
  assign aligned  = (offset[1:0] == 2'b00);
  assign valid    = in_range && aligned;

  assign ReadDataM = valid ? mem[index] : '0;

  always_ff @(posedge clk) begin
    if (MemWriteM && valid) begin
      mem[index] <= WriteDataM;
    end
  end
endmodule

// File: rtl/memory_stage.sv
// MEM stage: data memory access, MEM/WB register, writeback mux and a sticky
// access-error flag.
module memory_stage
  import mips_pkg::*;
#(
  parameter int                DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [WORD_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [WORD_W-1:0]     ALUOutM,
  input  logic [WORD_W-1:0]     WriteDataM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [WORD_W-1:0]     ReadDataW,
  output logic [WORD_W-1:0]     ALUOutW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [WORD_W-1:0]     ResultW,
  output logic                  MemErr
);
  logic [WORD_W-1:0] read_data_m;
  logic              addr_valid;
  logic              access;

  // The store is not gated by rst: a store in a reset cycle still lands.
  data_memory #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (BASE_ADDR)
  ) u_data_memory (
    .clk        (clk),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (read_data_m),
    .valid      (addr_valid)
  );

  assign access = MemWriteM || MemtoRegM;

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      MemErr    <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      ReadDataW <= read_data_m;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
      if (access && !addr_valid) begin
        MemErr <= 1'b1;
      end
    end
  end

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage: each driven cycle queues the
// expected W-side state, and a monitor compares it one edge later.
module tb_memory_stage;
  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        MemErr;

  typedef struct packed {
    logic [15:0] id;
    logic        rw;
    logic        m2r;
    logic        rd_known;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   next_id = 0;
  bit   done = 0;

  memory_stage dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .WriteRegM  (WriteRegM),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WriteRegW  (WriteRegW),
    .ResultW    (ResultW),
    .MemErr     (MemErr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL v%0d %s: got %h expected %h", id, nm, got, want);
    end
  endtask

  // driver: applies one cycle of inputs and queues what the W side must show
  task automatic issue(input logic r, input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic e_rw, input logic e_m2r, input logic e_rd_known,
                       input logic [31:0] e_rd, input logic [31:0] e_alu,
                       input logic [4:0] e_wr, input logic e_err);
    exp_t e;
    @(negedge clk);
    rst = r; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    e.id = next_id[15:0]; e.rw = e_rw; e.m2r = e_m2r; e.rd_known = e_rd_known;
    e.rd = e_rd; e.alu = e_alu; e.wr = e_wr; e.err = e_err;
    next_id++;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic reset_cycle(input logic mw, input logic [31:0] alu, input logic [31:0] wd);
    issue(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mw, alu, wd,
          5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    exp_t e;
    logic [31:0] res;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("RegWriteW", int'(e.id), {31'd0, RegWriteW}, {31'd0, e.rw});
      chk("MemtoRegW", int'(e.id), {31'd0, MemtoRegW}, {31'd0, e.m2r});
      chk("ALUOutW", int'(e.id), ALUOutW, e.alu);
      chk("WriteRegW", int'(e.id), {27'd0, WriteRegW}, {27'd0, e.wr});
      chk("MemErr", int'(e.id), {31'd0, MemErr}, {31'd0, e.err});
      if (e.rd_known) begin
        chk("ReadDataW", int'(e.id), ReadDataW, e.rd);
      end
      if (e.rd_known || !e.m2r) begin
        res = e.m2r ? e.rd : e.alu;
        chk("ResultW", int'(e.id), ResultW, res);
      end
    end
  end

  initial begin
    rst = 1'b1; RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      reset_cycle(1'($urandom_range(0, 1)), $urandom(), $urandom());
    end
    // store DEADBEEF to 0x10 (old word unknown), then load it
    issue(0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF, 5'd0,  0, 0, 0, 32'h0,         32'h10, 5'd0, 0);
    issue(0, 1, 1, 0, 32'h10, 32'h0,         5'd8,  1, 1, 1, 32'hDEAD_BEEF, 32'h10, 5'd8, 0);
    // read-during-write returns old word
    issue(0, 0, 0, 1, 32'h10, 32'h1111_1111, 5'd0,  0, 0, 1, 32'hDEAD_BEEF, 32'h10, 5'd0, 0);
    issue(0, 0, 1, 1, 32'h10, 32'h2222_2222, 5'd0,  0, 1, 1, 32'h1111_1111, 32'h10, 5'd0, 0);
    issue(0, 1, 1, 0, 32'h10, 32'h0,         5'd9,  1, 1, 1, 32'h2222_2222, 32'h10, 5'd9, 0);
    // ALU pass-through; 0xABC is out of range but no access, so no error
    issue(0, 1, 0, 0, 32'hABC, 32'h0,        5'd3,  1, 0, 1, 32'h0,         32'hABC, 5'd3, 0);
    // first and last words of the array
    issue(0, 0, 0, 1, 32'h3FC, 32'hCAFE_F00D, 5'd0, 0, 0, 0, 32'h0,         32'h3FC, 5'd0, 0);
    issue(0, 1, 1, 0, 32'h3FC, 32'h0,         5'd4, 1, 1, 1, 32'hCAFE_F00D, 32'h3FC, 5'd4, 0);
    issue(0, 0, 0, 1, 32'h0,   32'hA5A5_A5A5, 5'd0, 0, 0, 0, 32'h0,         32'h0,   5'd0, 0);
    issue(0, 1, 1, 0, 32'h0,   32'h0,         5'd5, 1, 1, 1, 32'hA5A5_A5A5, 32'h0,   5'd5, 0);
    // misaligned store: no write, sticky error
    issue(0, 0, 0, 1, 32'h12,  32'h5,         5'd0, 0, 0, 1, 32'h0,         32'h12,  5'd0, 1);
    issue(0, 1, 1, 0, 32'h10,  32'h0,         5'd6, 1, 1, 1, 32'h2222_2222, 32'h10,  5'd6, 1);
    for (int i = 0; i < 10; i++) begin
      issue(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'hA5A5_A5A5, 32'h0, 5'd0, 1);
    end
    // fresh reset, then non-access at all-ones must not set the flag
    reset_cycle(1'b0, $urandom(), $urandom());
    issue(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0, 5'd2, 1, 0, 1, 32'h0, 32'hFFFF_FFFF, 5'd2, 0);
    issue(0, 0, 0, 0, 32'h0,         32'h0, 5'd0, 0, 0, 1, 32'hA5A5_A5A5, 32'h0, 5'd0, 0);
    // out-of-range load still writes back zero and flags
    issue(0, 1, 1, 0, 32'h400, 32'h0, 5'd7, 1, 1, 1, 32'h0, 32'h400, 5'd7, 1);
    issue(0, 0, 0, 0, 32'h0,   32'h0, 5'd0, 0, 0, 1, 32'hA5A5_A5A5, 32'h0, 5'd0, 1);
    // reset clears the flag; a store during reset still lands; memory persists
    reset_cycle(1'b1, 32'h20, 32'h0000_0077);
    issue(0, 1, 1, 0, 32'h10, 32'h0, 5'd10, 1, 1, 1, 32'h2222_2222, 32'h10, 5'd10, 0);
    issue(0, 1, 1, 0, 32'h20, 32'h0, 5'd11, 1, 1, 1, 32'h0000_0077, 32'h20, 5'd11, 0);
    issue(0, 1, 1, 0, 32'h3FC, 32'h0, 5'd12, 1, 1, 1, 32'hCAFE_F00D, 32'h3FC, 5'd12, 0);

    @(negedge clk);
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    done = 1'b1;
  end

  // final report with a bounded drain
  initial begin
    int budget;
    budget = 0;
    while (!done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (!done || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0", done, exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
